// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer in front of the data memory.
// Optional misaligned-access check enabled by defining DMEM_ARB_ALIGN_CHK_EN.
module dmem_arbiter #(
  parameter int MEM_RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [2:0]  c_funct3,
  output logic        c_ack,
  output logic [31:0] c_rdata,
  output logic        c_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [2:0]  m_funct3,
  input  logic [31:0] m_rdata
);

  typedef enum logic [2:0] {
    IDLE, WR, RD, CAPT, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] crd_q, crd_d;
  logic [31:0] drd_q, drd_d;
  logic        err_q, err_d;

  logic        pick_d;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_f3;
  logic        mis;

  // last/gnt encoding: 1 = port D
  always_comb begin
    pick_d    = d_req & (~c_req | ~last_q);
    sel_we    = pick_d ? d_we : c_we;
    sel_addr  = pick_d ? d_addr : c_addr;
    sel_wdata = pick_d ? d_wdata : c_wdata;
    sel_f3    = pick_d ? d_funct3 : c_funct3;
    mis = ((sel_f3[1:0] == 2'b01) & sel_addr[0])
        | ((sel_f3[1:0] == 2'b10) & (sel_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    crd_d   = crd_q;
    drd_d   = drd_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (c_req | d_req) begin
          gnt_d   = pick_d;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          f3_d    = sel_f3;
          cnt_d   = 3'd0;
          if (pick_d) drd_d = 32'd0;
          else        crd_d = 32'd0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
          err_d = mis;
          if (mis)         state_d = DONE;
          else if (sel_we) state_d = WR;
          else             state_d = RD;
`else
          err_d   = 1'b0;
          state_d = sel_we ? WR : RD;
`endif
        end
      end
      WR: state_d = DONE;
      RD: begin
        if (cnt_q == 3'(MEM_RD_LAT - 1)) begin
          cnt_d   = 3'd0;
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      CAPT: begin
        if (gnt_q) drd_d = m_rdata;
        else       crd_d = m_rdata;
        state_d = DONE;
      end
      DONE: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      crd_q   <= 32'd0;
      drd_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      crd_q   <= crd_d;
      drd_q   <= drd_d;
      err_q   <= err_d;
    end
  end

  assign m_read   = (state_q == RD);
  assign m_write  = (state_q == WR);
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign m_funct3 = f3_q;
  assign c_ack    = (state_q == DONE) & ~gnt_q;
  assign d_ack    = (state_q == DONE) & gnt_q;
  assign c_rdata  = crd_q;
  assign d_rdata  = drd_q;
`ifdef DMEM_ARB_ALIGN_CHK_EN
  assign c_err = c_ack & err_q;
  assign d_err = d_ack & err_q;
`else
  assign c_err = 1'b0;
  assign d_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-addressed memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, c_ack, c_err;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [2:0]  c_funct3;
  logic        d_req, d_we, d_ack, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_funct3;
  logic        m_read, m_write;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_funct3;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:255];

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_RD_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_funct3(c_funct3),
    .c_ack(c_ack), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_funct3(m_funct3), .m_rdata(m_rdata)
  );

  // memory model: combinational read, size/sign from funct3
  always_comb begin
    logic [7:0] a;
    a = m_addr[7:0];
    case (m_funct3)
      3'b000: m_rdata = {{24{mem[a][7]}}, mem[a]};
      3'b100: m_rdata = {24'd0, mem[a]};
      3'b001: m_rdata = {{16{mem[a+8'd1][7]}}, mem[a+8'd1], mem[a]};
      3'b101: m_rdata = {16'd0, mem[a+8'd1], mem[a]};
      default: m_rdata = {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
    endcase
  end

  always @(posedge clk) begin
    if (m_write) begin
      case (m_funct3[1:0])
        2'b00: mem[m_addr[7:0]] <= m_wdata[7:0];
        2'b01: begin
          mem[m_addr[7:0]]       <= m_wdata[7:0];
          mem[m_addr[7:0]+8'd1]  <= m_wdata[15:8];
        end
        default: begin
          mem[m_addr[7:0]]       <= m_wdata[7:0];
          mem[m_addr[7:0]+8'd1]  <= m_wdata[15:8];
          mem[m_addr[7:0]+8'd2]  <= m_wdata[23:16];
          mem[m_addr[7:0]+8'd3]  <= m_wdata[31:24];
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Tick until the selected port acks (bounded); n = cycles waited.
  task automatic run(input bit isd, output int n, output bit rdp,
                     output bit wrp, output bit oth);
    n = 0; rdp = 0; wrp = 0; oth = 0;
    do begin
      tick();
      n++;
      if (m_read) rdp = 1;
      if (m_write) wrp = 1;
      if (isd ? c_ack : d_ack) oth = 1;
    end while (!(isd ? d_ack : c_ack) && n < 20);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int n;
  bit rdp, wrp, oth;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_funct3 = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_funct3 = 0;
    tick();
    tick();
    chk("rst_m_read", {31'd0, m_read}, 32'd0);
    chk("rst_m_write", {31'd0, m_write}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_acks", {30'd0, c_ack, d_ack}, 32'd0);
    chk("rst_rdata", c_rdata | d_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // C store SW 0x10
    c_req = 1; c_we = 1; c_addr = 32'h10;
    c_wdata = 32'hDEADBEEF; c_funct3 = 3'b010;
    tick();
    chk("st_m_write", {31'd0, m_write}, 32'd1);
    chk("st_m_addr", m_addr, 32'h10);
    chk("st_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("st_ack_early", {31'd0, c_ack}, 32'd0);
    tick();
    chk("st_ack", {31'd0, c_ack}, 32'd1);
    chk("st_m_write_off", {31'd0, m_write}, 32'd0);
    chk("st_rdata0", c_rdata, 32'd0);
    // back-to-back C load
    c_we = 0; c_wdata = 0;
    tick();
    tick();
    chk("ld_m_read1", {31'd0, m_read}, 32'd1);
    chk("ld_m_addr", m_addr, 32'h10);
    tick();
    chk("ld_m_read2", {31'd0, m_read}, 32'd1);
    tick();
    chk("ld_capt_read", {31'd0, m_read}, 32'd0);
    chk("ld_capt_ack", {31'd0, c_ack}, 32'd0);
    tick();
    chk("ld_ack", {31'd0, c_ack}, 32'd1);
    chk("ld_rdata", c_rdata, 32'hDEADBEEF);
    c_req = 0;

    // contention after reset: C, D, C, D
    do_reset();
    c_req = 1; c_we = 0; c_addr = 32'h10; c_funct3 = 3'b010;
    d_req = 1; d_we = 0; d_addr = 32'h10; d_funct3 = 3'b010;
    for (int k = 0; k < 4; k++) begin
      run(k[0], n, rdp, wrp, oth);
      chk($sformatf("rr%0d_cyc", k), n, (k == 0) ? 4 : 5);
      chk($sformatf("rr%0d_other", k), {31'd0, oth}, 32'd0);
      chk($sformatf("rr%0d_rdata", k),
          k[0] ? d_rdata : c_rdata, 32'hDEADBEEF);
    end
    c_req = 0; d_req = 0;
    tick();

    // D store SB 0xA5 to 0x21, then LBU
    d_req = 1; d_we = 1; d_addr = 32'h21;
    d_wdata = 32'h000000A5; d_funct3 = 3'b000;
    run(1, n, rdp, wrp, oth);
    chk("dsb_cyc", n, 2);
    chk("dsb_wr", {31'd0, wrp}, 32'd1);
    chk("dsb_cack", {31'd0, oth}, 32'd0);
    chk("dsb_rdata0", d_rdata, 32'd0);
    d_we = 0; d_wdata = 0; d_funct3 = 3'b100;
    tick();
    run(1, n, rdp, wrp, oth);
    chk("dlbu_cyc", n, 4);
    chk("dlbu_rdata", d_rdata, 32'h000000A5);
    chk("dlbu_cack", {31'd0, oth}, 32'd0);
    chk("c_rdata_hold", c_rdata, 32'hDEADBEEF);
    d_req = 0;
    tick();

    // async reset during RD
    c_req = 1; c_we = 0; c_addr = 32'h10; c_funct3 = 3'b010;
    tick();
    chk("ar_m_read", {31'd0, m_read}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_read_off", {31'd0, m_read}, 32'd0);
    chk("ar_m_addr", m_addr, 32'd0);
    chk("ar_rdata", c_rdata | d_rdata, 32'd0);
    tick();
    chk("ar_no_ack", {30'd0, c_ack, d_ack}, 32'd0);
    rst = 1'b0;
    run(0, n, rdp, wrp, oth);
    chk("ar_reissue_cyc", n, 4);
    chk("ar_reissue_rd", c_rdata, 32'hDEADBEEF);
    c_req = 0;
    tick();

    // misaligned LW at 0x13
    c_req = 1; c_we = 0; c_addr = 32'h13; c_funct3 = 3'b010;
    run(0, n, rdp, wrp, oth);
`ifdef DMEM_ARB_ALIGN_CHK_EN
    chk("mis_cyc", n, 1);
    chk("mis_err", {31'd0, c_err}, 32'd1);
    chk("mis_rdata", c_rdata, 32'd0);
    chk("mis_no_read", {31'd0, rdp}, 32'd0);
`else
    chk("mis_cyc", n, 4);
    chk("mis_err", {31'd0, c_err}, 32'd0);
    chk("mis_read", {31'd0, rdp}, 32'd1);
`endif
    c_req = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the byte-addressable synchronous data memory. It shares the single memory port between the core load/store path (port C) and a DMA/debug loader (port D) using round-robin. It drives the memory strobes for exactly the cycles the memory needs, then returns read data with a one-cycle acknowledge. It sits between the core/loader and the data memory instance at top level.

## Interface
Parameters:
- MEM_RD_LAT, 2: cycles m_read and m_addr are held for a read; valid range 1..7.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- c_req / d_req  in  1  access request, held until ack
- c_we / d_we  in  1  1 = store, 0 = load
- c_addr / d_addr  in  32  byte address
- c_wdata / d_wdata  in  32  store data
- c_funct3 / d_funct3  in  3  access size/sign code, forwarded to memory
- c_ack / d_ack  out  1  one-cycle completion pulse
- c_rdata / d_rdata  out  32  load result, valid while ack=1
- c_err / d_err  out  1  misaligned-access flag, valid while ack=1
- m_read  out  1  memory read enable
- m_write  out  1  memory write enable
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_funct3  out  3  memory access code
- m_rdata  in  32  memory read data

## Operation
- FSM states: IDLE, WR, RD, CAPT, DONE. Reset state is IDLE.
- IDLE:
  - Samples c_req/d_req.
  - If exactly one is high, that port is granted.
  - If both are high, the port not granted last wins.
  - The last-granted pointer resets to D, so C wins the first contention.
  - On grant, latches we/addr/wdata/funct3 into m_* registers.
  - Goes to WR if we=1, otherwise RD.
- WR: m_write=1 for exactly one cycle, then DONE.
- RD:
  - m_read=1 and m_addr stable for MEM_RD_LAT cycles, counted by a 3-bit counter.
  - Then CAPT.
- CAPT:
  - m_read=0.
  - m_rdata is registered into the granted port's rdata at the end of the cycle.
  - Then DONE.
- DONE:
  - Granted port's ack=1. For writes, rdata=0.
  - Updates the last-granted pointer, then IDLE.
- Requester rule: in the cycle after ack, req must be deasserted or carry a new transaction. Fields must be stable from req rise to ack.
- Non-granted port: ack=0, err=0, rdata holds its last value.
- m_read/m_write are 0 in every state except WR/RD. m_addr/m_wdata/m_funct3 hold their last value when idle.
- funct3 is forwarded unmodified; size and sign handling is the memory's job.

## Timing
- Request sampled in IDLE cycle N:
  - Store: m_write high in cycle N+1, ack in N+2.
  - Load: m_read high N+1..N+MEM_RD_LAT, capture at N+MEM_RD_LAT+1, ack at N+MEM_RD_LAT+2 (N+4 at default).
- Sustained throughput: one store per 3 cycles, one load per MEM_RD_LAT+3 cycles.
- At most one outstanding transaction. Both acks are never high together.
- Reset values: all outputs 0, counter 0, pointer=D.
- Reset mid-transaction: abort immediately; the pending transaction is dropped with no ack. The requester re-issues after rst falls.
- A request dropped before ack while in IDLE is never granted. Dropping req after grant violates protocol: the access completes and ack is still pulsed.

## Configuration
- DMEM_ARB_ALIGN_CHK_EN defined:
  - In IDLE, a granted access is misaligned if funct3[1:0]=01 with addr[0]=1, or funct3[1:0]=10 with addr[1:0]!=0.
  - Misaligned accesses skip WR/RD, so m_read/m_write stay 0.
  - They go straight to DONE next cycle with ack=1, err=1, rdata=0. Ack is at N+1.
- DMEM_ARB_ALIGN_CHK_EN undefined:
  - No check; every access goes to the memory.
  - err is tied to 0.

## Test plan
- C store: addr=0x10, wdata=0xDEADBEEF, funct3=010. Expect m_write for 1 cycle with m_addr=0x10 and c_ack at N+2. Then C load of the same address: c_rdata=0xDEADBEEF with c_ack at N+4.
- C and D both request loads in the same IDLE cycle after reset. C is served first, then D. With both held continuously, grants alternate C, D, C, D.
- D store SB 0x000000A5 to 0x21, then D load LBU 0x21. Expect d_rdata=0x000000A5. c_ack stays 0 throughout.
- Assert rst asynchronously during RD of a C load. Expect m_read=0 immediately, no c_ack, and all outputs 0. The C load re-issued after reset completes with the correct data.
- With DMEM_ARB_ALIGN_CHK_EN: C load LW at 0x13. Expect c_ack at N+1, c_err=1, c_rdata=0, and no m_read pulse. Without the macro the same access asserts m_read and c_err=0.
